// File: rtl/product_bcd.sv
// product_bcd
//   Converts a 16-bit multiplier product to sign + five BCD digits with a
//   serial double-dabble engine (one shift per clock, 16 iterations).
//
//   Parameter:
//     SIGNED_IN : 1 = Prod is two's complement, 0 = Prod is unsigned
//   Optional feature macro:
//     PRODUCT_BCD_ZERO_BLANK_EN : compile in leading-zero blanking flags
//   Ports:
//     Clk      in   system clock, rising edge
//     Reset_n  in   synchronous active-low reset
//     Start    in   single-cycle conversion request (accepted only when idle)
//     Prod     in   16-bit product {A[7:0], B[7:0]}
//     Busy     out  conversion in progress
//     Done     out  one-cycle pulse, result registers just updated
//     Sign     out  1 = result negative
//     Digits   out  five BCD digits of |Prod|, [19:16] most significant
//     Blank    out  per-digit leading-zero flag, bit i covers Digits[4i+3:4i]
module product_bcd #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [15:0] Prod,
    output logic        Busy,
    output logic        Done,
    output logic        Sign,
    output logic [19:0] Digits,
    output logic [4:0]  Blank
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [19:0] bcd_q,    bcd_d;
    logic [15:0] mag_q,    mag_d;
    logic        neg_q,    neg_d;
    logic        sign_q,   sign_d;
    logic [19:0] digits_q, digits_d;

    logic [19:0] bcd_adj;
    logic [19:0] bcd_next;
    logic [15:0] mag_next;
    logic [3:0]  dig;
    logic        start_neg;

    // One double-dabble step: add 3 to every digit >= 5, then shift the
    // magnitude MSB into the scratch BCD register.
    always_comb begin
        bcd_adj = bcd_q;
        dig     = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            dig = bcd_q[4*i +: 4];
            bcd_adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
        bcd_next = {bcd_adj[18:0], mag_q[15]};
        mag_next = {mag_q[14:0], 1'b0};
    end

    assign start_neg = Prod[15] & SIGNED_IN;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        sign_d   = sign_q;
        digits_d = digits_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    neg_d   = start_neg;
                    mag_d   = start_neg ? (~Prod + 16'd1) : Prod;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = bcd_next;
                mag_d = mag_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d  = S_DONE;
                    digits_d = bcd_next;
                    sign_d   = neg_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bcd_q    <= '0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            sign_q   <= 1'b0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            mag_q    <= mag_d;
            neg_q    <= neg_d;
            sign_q   <= sign_d;
            digits_q <= digits_d;
        end
    end

`ifdef PRODUCT_BCD_ZERO_BLANK_EN
    logic [4:0] blank_q, blank_d, blank_calc;

    // A digit is blank when it and every more significant digit are zero;
    // the units digit always shows.
    always_comb begin
        blank_calc    = '0;
        blank_calc[4] = (bcd_next[19:16] == 4'd0);
        blank_calc[3] = blank_calc[4] & (bcd_next[15:12] == 4'd0);
        blank_calc[2] = blank_calc[3] & (bcd_next[11:8]  == 4'd0);
        blank_calc[1] = blank_calc[2] & (bcd_next[7:4]   == 4'd0);
        blank_d = blank_q;
        if (state_q == S_CONV && cnt_q == 4'd15) begin
            blank_d = blank_calc;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign Blank = blank_q;
`else
    assign Blank = '0;
`endif

    assign Busy   = (state_q != S_IDLE);
    assign Done   = (state_q == S_DONE);
    assign Sign   = sign_q;
    assign Digits = digits_q;

endmodule
